rv_fetch_aligner: RTL

Sequencer between the instruction fetch port and the decompressing decoder. Accepts 32-bit, 4-byte-aligned fetch words. Slices them into 16-bit parcels in a small queue. Presents one complete instruction per handshake: a compressed parcel, or two parcels forming a 32-bit instruction. Each instruction comes with its PC. Handles redirects, including targets on odd halfwords, and instructions that straddle fetch words.

---
 rtl/rv_fetch_aligner.sv | 114 +++++++++++
 1 files changed

// File: rtl/rv_fetch_aligner.sv
// rtl/rv_fetch_aligner.sv - splits fetch words into parcels and presents whole RISC-V instructions
module rv_fetch_aligner #(
    parameter bit          rv64     = 1'b1,
    parameter logic [63:0] reset_pc = 64'h0,
    localparam int         xlen     = rv64 ? 64 : 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect,
    input  logic [xlen-1:0] redirect_pc,
    output logic [xlen-1:0] fetch_addr,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_data,
    output logic            fetch_ready,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [xlen-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam logic [xlen-1:0] reset_pc_x = reset_pc[xlen-1:0];
    localparam logic [xlen-1:0] word_mask  = ~xlen'(3);
    localparam logic [xlen-1:0] half_mask  = ~xlen'(1);

    logic [15:0]     q         [4];
    logic [15:0]     shifted   [4];
    logic [15:0]     q_next    [4];
    logic [2:0]      count;
    logic [2:0]      count_next;
    logic [2:0]      survivors;
    logic [2:0]      pop_cnt;
    logic [2:0]      push_cnt;
    logic [xlen-1:0] pc;
    logic            skip;
    logic            compressed;
    logic            accept;
    logic            consume;

    assign compressed  = q[0][1:0] != 2'b11;
    assign inst_valid  = !redirect && ((count != 3'd0 && compressed) || count >= 3'd2);
    assign fetch_ready = !redirect && count <= 3'd2;
    assign accept      = fetch_valid && fetch_ready;
    assign consume     = inst_valid && inst_ready;
    assign inst_pc     = pc;

    assign pop_cnt    = !consume ? 3'd0 : (compressed ? 3'd1 : 3'd2);
    assign push_cnt   = !accept  ? 3'd0 : (skip ? 3'd1 : 3'd2);
    assign survivors  = count - pop_cnt;
    assign count_next = survivors + push_cnt;

    // Upper half is zeroed for compressed parcels so the output does not change
    // when a new word lands behind a stalled instruction.
    always_comb begin
        inst = 32'h0000_0000;
        if (count >= 3'd2 && !compressed) begin
            inst = {q[1], q[0]};
        end else if (count != 3'd0) begin
            inst = {16'h0000, q[0]};
        end
    end

    // Pop from the front first, then append the new parcels after the survivors.
    always_comb begin
        shifted = q;
        case (pop_cnt)
            3'd1: begin
                shifted[0] = q[1];
                shifted[1] = q[2];
                shifted[2] = q[3];
            end
            3'd2: begin
                shifted[0] = q[2];
                shifted[1] = q[3];
            end
            default: ;
        endcase
        q_next = shifted;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == survivors) begin
                    q_next[i] = skip ? fetch_data[31:16] : fetch_data[15:0];
                end else if (!skip && 3'(i) == survivors + 3'd1) begin
                    q_next[i] = fetch_data[31:16];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q          <= '{default: 16'h0000};
            count      <= 3'd0;
            skip       <= reset_pc_x[1];
            fetch_addr <= reset_pc_x & word_mask;
            pc         <= reset_pc_x;
        end else if (redirect) begin
            count      <= 3'd0;
            skip       <= redirect_pc[1];
            fetch_addr <= redirect_pc & word_mask;
            pc         <= redirect_pc & half_mask;
        end else begin
            q     <= q_next;
            count <= count_next;
            if (accept) begin
                fetch_addr <= fetch_addr + xlen'(4);
                skip       <= 1'b0;
            end
            if (consume) begin
                pc <= pc + (compressed ? xlen'(2) : xlen'(4));
            end
        end
    end

endmodule
